// File: rtl/drink_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : drink_pkg
//  Description : Shared money constants, coin and FSM-state types for the
//                drink vending payout path.
//  Contents    : MONEY_W, HALF_VAL, ONE_VAL, coin_e, state_e, coin_value()
//  Revision    : 1.0  initial release
// ============================================================================
package drink_pkg;

    localparam int MONEY_W = 8;

    localparam logic [MONEY_W-1:0] HALF_VAL = 8'd5;
    localparam logic [MONEY_W-1:0] ONE_VAL  = 8'd10;

    typedef enum logic {
        COIN_ONE  = 1'b0,
        COIN_HALF = 1'b1
    } coin_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SELECT   = 3'd1,
        S_EJECT    = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_DONE     = 3'd4,
        S_FAULT    = 3'd5
    } state_e;

    function automatic logic [MONEY_W-1:0] coin_value(input coin_e c);
        return (c == COIN_ONE) ? ONE_VAL : HALF_VAL;
    endfunction

endpackage
`default_nettype wire

// File: rtl/coin_inventory.sv
`default_nettype none
// ============================================================================
//  Module      : coin_inventory
//  Description : Saturating up/down coin counter for one denomination.
//                inc and dec together leave the count unchanged; increment
//                saturates at all-ones, decrement stops at zero.
//  Ports       : clk, reset (sync, active-high, loads INIT_VAL)
//                en_i     - clock enable, low holds the count
//                inc_i    - add one coin (refill)
//                dec_i    - remove one coin (payout)
//                count_o  - current stock
//  Revision    : 1.0  initial release
// ============================================================================
module coin_inventory #(
    parameter int INV_W    = 8,
    parameter int INIT_VAL = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [INV_W-1:0] count_o
);

    logic [INV_W-1:0] count_q;
    logic [INV_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        unique case ({inc_i, dec_i})
            2'b10: if (count_q != '1) count_d = count_q + INV_W'(1);
            2'b01: if (count_q != '0) count_d = count_q - INV_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= INV_W'(INIT_VAL);
        end else if (en_i) begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
//  Module      : change_dispenser
//  Description : Pays a change request through the coin hopper one coin at a
//                time, one-dollar coins first then half-dollar coins, with an
//                eject/ack handshake, inventory tracking and jam detection.
//  Ports       : clk, reset (sync, active-high), ena (clock enable)
//                req_valid/req_amount/req_ready - change request handshake
//                hopper_ack                     - coin-passed pulse
//                refill_one/refill_half         - stock top-up pulses
//                eject_one/eject_half           - one-cycle eject commands
//                busy, done, short, shortfall   - request status
//                jam                            - sticky hopper fault
//                inv_one/inv_half               - coin stock
//  Revision    : 1.0  initial release
// ============================================================================
module change_dispenser
    import drink_pkg::*;
#(
    parameter int INV_W       = 8,
    parameter int INIT_ONE    = 20,
    parameter int INIT_HALF   = 20,
    parameter int ACK_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ena,
    input  logic               req_valid,
    input  logic [MONEY_W-1:0] req_amount,
    output logic               req_ready,
    input  logic               hopper_ack,
    input  logic               refill_one,
    input  logic               refill_half,
    output logic               eject_one,
    output logic               eject_half,
    output logic               busy,
    output logic               done,
    output logic               short,
    output logic [MONEY_W-1:0] shortfall,
    output logic               jam,
    output logic [INV_W-1:0]   inv_one,
    output logic [INV_W-1:0]   inv_half
);

    state_e             state_q, state_d;
    coin_e              coin_q, coin_d;
    logic [MONEY_W-1:0] rem_q, rem_d;
    logic [MONEY_W-1:0] shortfall_q, shortfall_d;
    logic [TO_W-1:0]    timer_q, timer_d;
    logic               short_q, short_d;
    logic               jam_q, jam_d;
    logic               done_q, done_d;

    logic               w_ack;
    logic [TO_W-1:0]    w_timer_inc;

    // An ack only counts while a coin is actually in flight.
    assign w_ack       = (state_q == S_WAIT_ACK) && hopper_ack;
    assign w_timer_inc = timer_q + TO_W'(1);

    always_comb begin
        state_d     = state_q;
        coin_d      = coin_q;
        rem_d       = rem_q;
        shortfall_d = shortfall_q;
        timer_d     = timer_q;
        short_d     = short_q;
        jam_d       = jam_q;
        done_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    rem_d       = req_amount;
                    short_d     = 1'b0;
                    shortfall_d = '0;
                    state_d     = S_SELECT;
                end
            end
            S_SELECT: begin
                if (rem_q >= ONE_VAL && inv_one != '0) begin
                    coin_d  = COIN_ONE;
                    state_d = S_EJECT;
                end else if (rem_q >= HALF_VAL && inv_half != '0) begin
                    coin_d  = COIN_HALF;
                    state_d = S_EJECT;
                end else begin
                    // Result flags are loaded on the way into DONE so they
                    // are already valid while the done pulse is high.
                    done_d      = 1'b1;
                    short_d     = (rem_q != '0);
                    shortfall_d = rem_q;
                    state_d     = S_DONE;
                end
            end
            S_EJECT: begin
                timer_d = '0;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (hopper_ack) begin
                    // SELECT only picks a coin that fits, so no wrap here.
                    rem_d   = rem_q - coin_value(coin_q);
                    state_d = S_SELECT;
                end else if (w_timer_inc == TO_W'(ACK_TIMEOUT)) begin
                    jam_d       = 1'b1;
                    done_d      = 1'b1;
                    short_d     = 1'b1;
                    shortfall_d = rem_q;
                    state_d     = S_FAULT;
                end else begin
                    timer_d = w_timer_inc;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            coin_q      <= COIN_ONE;
            rem_q       <= '0;
            shortfall_q <= '0;
            timer_q     <= '0;
            short_q     <= 1'b0;
            jam_q       <= 1'b0;
            done_q      <= 1'b0;
        end else if (ena) begin
            state_q     <= state_d;
            coin_q      <= coin_d;
            rem_q       <= rem_d;
            shortfall_q <= shortfall_d;
            timer_q     <= timer_d;
            short_q     <= short_d;
            jam_q       <= jam_d;
            done_q      <= done_d;
        end
    end

    coin_inventory #(
        .INV_W    (INV_W),
        .INIT_VAL (INIT_ONE)
    ) u_inv_one (
        .clk     (clk),
        .reset   (reset),
        .en_i    (ena),
        .inc_i   (refill_one),
        .dec_i   (w_ack && (coin_q == COIN_ONE)),
        .count_o (inv_one)
    );

    coin_inventory #(
        .INV_W    (INV_W),
        .INIT_VAL (INIT_HALF)
    ) u_inv_half (
        .clk     (clk),
        .reset   (reset),
        .en_i    (ena),
        .inc_i   (refill_half),
        .dec_i   (w_ack && (coin_q == COIN_HALF)),
        .count_o (inv_half)
    );

    // Pulses are gated by ena so a frozen block never repeats a command.
    assign eject_one  = ena && (state_q == S_EJECT) && (coin_q == COIN_ONE);
    assign eject_half = ena && (state_q == S_EJECT) && (coin_q == COIN_HALF);
    assign done       = ena && done_q;
    assign req_ready  = ena && (state_q == S_IDLE) && !jam_q;
    assign busy       = (state_q != S_IDLE);
    assign short      = short_q;
    assign shortfall  = shortfall_q;
    assign jam        = jam_q;

endmodule
`default_nettype wire
